// File: rtl/ddr5_phy_read_counters.sv
// ddr5_phy_read_counters
// Read-path burst timing for the DDR5 PHY. Each accepted read strobe runs one
// burst through PREAMBLE -> DATA (+ optional CRC cycle) -> POSTAMBLE, driving
// the DQS receive gate, DQ capture qualifiers and phase-done pulses.
//
// Ports
//   clk_i             PHY clock, rising edge
//   rst_i             asynchronous active-low reset
//   rd_en_i           single-cycle read strobe, latency-aligned
//   precycle_i[2:0]   preamble length (0 -> 1, >4 -> 4)
//   postcycle_i[1:0]  postamble length (0 -> 1, 3 -> 2)
//   burstlength_i[1:0] 01 = BC8 (4 data cycles), otherwise BL16 (8)
//   dram_crc_en_i     append one CRC cycle after data
//   rd_state_o[1:0]   00 IDLE, 01 PREAMBLE, 10 DATA, 11 POSTAMBLE
//   dqs_gate_o        DQS receiver gate
//   rddata_valid_o    high on data cycles
//   crc_check_o       high on the CRC cycle
//   preamble_done_o   last PREAMBLE cycle
//   rddata_done_o     last DATA cycle (incl. CRC)
//   postamble_done_o  last POSTAMBLE cycle
//   interamble_o      PREAMBLE entered directly from DATA/POSTAMBLE
//   rd_err_o          pulse on the cycle after a dropped strobe
//
// All outputs are registered: the Moore decode is applied to the next-state
// values so each output lines up with the state it describes.
module ddr5_phy_read_counters (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rd_en_i,
    input  logic [2:0] precycle_i,
    input  logic [1:0] postcycle_i,
    input  logic [1:0] burstlength_i,
    input  logic       dram_crc_en_i,
    output logic [1:0] rd_state_o,
    output logic       dqs_gate_o,
    output logic       rddata_valid_o,
    output logic       crc_check_o,
    output logic       preamble_done_o,
    output logic       rddata_done_o,
    output logic       postamble_done_o,
    output logic       interamble_o,
    output logic       rd_err_o
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PRE  = 2'b01,
        S_DATA = 2'b10,
        S_POST = 2'b11
    } state_t;

    // Burst configuration captured on PREAMBLE entry
    typedef struct packed {
        logic [2:0]       pre;       // 1..4
        logic [1:0]       post;      // 1..2
        logic [CNT_W-1:0] data_len;  // 4 or 8
        logic             crc;
    } cfg_t;

    typedef struct packed {
        logic [1:0] state;
        logic       gate;
        logic       valid;
        logic       crc;
        logic       pre_done;
        logic       data_done;
        logic       post_done;
        logic       inter;
    } out_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             pend_q, pend_nxt;
    logic             inter_q, inter_nxt;
    cfg_t             cfg_q, cfg_nxt;
    cfg_t             cfg_in;
    logic             err_nxt;
    out_t             out_q, out_nxt;
    logic             err_q;

    logic [CNT_W-1:0] pre_last;
    logic [CNT_W-1:0] data_last;
    logic [CNT_W-1:0] post_last;

    // Moore decode of a (state, cnt, cfg, interamble) tuple
    function automatic out_t decode(input state_t st, input logic [CNT_W-1:0] cnt,
                                    input cfg_t cfg, input logic inter);
        out_t             o;
        logic [CNT_W-1:0] total;
        total       = cfg.data_len + CNT_W'(cfg.crc);
        o           = '0;
        o.state     = st;
        o.gate      = (st != S_IDLE);
        o.valid     = (st == S_DATA) && (cnt < cfg.data_len);
        o.crc       = (st == S_DATA) && cfg.crc && (cnt == cfg.data_len);
        o.pre_done  = (st == S_PRE)  && (cnt == CNT_W'(cfg.pre) - CNT_W'(1));
        o.data_done = (st == S_DATA) && (cnt == total - CNT_W'(1));
        o.post_done = (st == S_POST) && (cnt == CNT_W'(cfg.post) - CNT_W'(1));
        o.inter     = (st == S_PRE)  && inter;
        return o;
    endfunction

    // Clamp mode-register inputs into the configuration to be latched
    always_comb begin
        cfg_in = '0;
        if (precycle_i == 3'd0) begin
            cfg_in.pre = 3'd1;
        end else if (precycle_i > 3'd4) begin
            cfg_in.pre = 3'd4;
        end else begin
            cfg_in.pre = precycle_i;
        end
        if (postcycle_i == 2'd0) begin
            cfg_in.post = 2'd1;
        end else if (postcycle_i == 2'd3) begin
            cfg_in.post = 2'd2;
        end else begin
            cfg_in.post = postcycle_i;
        end
        cfg_in.data_len = (burstlength_i == 2'b01) ? CNT_W'(4) : CNT_W'(8);
        cfg_in.crc      = dram_crc_en_i;
    end

    assign pre_last  = CNT_W'(cfg_q.pre) - CNT_W'(1);
    assign data_last = cfg_q.data_len + CNT_W'(cfg_q.crc) - CNT_W'(1);
    assign post_last = CNT_W'(cfg_q.post) - CNT_W'(1);

    // Next-state, counter, pending and error logic
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + CNT_W'(1);
        pend_nxt  = pend_q;
        inter_nxt = inter_q;
        cfg_nxt   = cfg_q;
        err_nxt   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rd_en_i) begin
                    state_nxt = S_PRE;
                    inter_nxt = 1'b0;
                    cfg_nxt   = cfg_in;
                end
            end
            S_PRE: begin
                err_nxt = rd_en_i;
                if (cnt_q == pre_last) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (rd_en_i) begin
                    if (pend_q) begin
                        err_nxt = 1'b1;
                    end else begin
                        pend_nxt = 1'b1;
                    end
                end
                if (cnt_q == data_last) begin
                    cnt_nxt = '0;
                    // Back-to-back read: skip postamble straight into preamble
                    if (pend_q || rd_en_i) begin
                        state_nxt = S_PRE;
                        inter_nxt = 1'b1;
                        pend_nxt  = 1'b0;
                        cfg_nxt   = cfg_in;
                    end else begin
                        state_nxt = S_POST;
                    end
                end
            end
            S_POST: begin
                if (rd_en_i) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = '0;
                    inter_nxt = 1'b1;
                    cfg_nxt   = cfg_in;
                end else if (cnt_q == post_last) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        out_nxt = decode(state_nxt, cnt_nxt, cfg_nxt, inter_nxt);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            inter_q <= 1'b0;
            cfg_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            pend_q  <= pend_nxt;
            inter_q <= inter_nxt;
            cfg_q   <= cfg_nxt;
            out_q   <= out_nxt;
            err_q   <= err_nxt;
        end
    end

    assign rd_state_o       = out_q.state;
    assign dqs_gate_o       = out_q.gate;
    assign rddata_valid_o   = out_q.valid;
    assign crc_check_o      = out_q.crc;
    assign preamble_done_o  = out_q.pre_done;
    assign rddata_done_o    = out_q.data_done;
    assign postamble_done_o = out_q.post_done;
    assign interamble_o     = out_q.inter;
    assign rd_err_o         = err_q;

endmodule
